// File: rtl/mux_arb_pkg.sv
// -----------------------------------------------------------------------------
// mux_arb_pkg
// Shared types and helpers for the round-robin mux arbiter.
//   arb_state_t : arbiter FSM states (ARB = free arbitration, LOCK = stall hold)
//   N_REQ_DEF   : default requester count
//   W_DEF       : default data width
//   wrap_inc()  : index + 1 modulo n, valid for non-power-of-2 n
// Build option used by the arbiter: MUX_RR_ARB_OUT_REG_EN
// -----------------------------------------------------------------------------
package mux_arb_pkg;

    typedef enum logic [0:0] {ARB, LOCK} arb_state_t;

    localparam int N_REQ_DEF = 4;
    localparam int W_DEF     = 8;

    // idx is always in 0..n-1, so a compare replaces the modulo.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// -----------------------------------------------------------------------------
// rr_prio_pick
// Combinational rotating-priority picker. Returns the first set bit of
// req_vld scanning ptr, ptr+1, ... N_REQ-1, 0, ... ptr-1.
// Ports:
//   req_vld [N_REQ]  in   per-requester valid
//   ptr     [SEL_W]  in   highest-priority index (0..N_REQ-1)
//   winner  [SEL_W]  out  selected index (0 when nothing is valid)
//   any     [1]      out  at least one requester valid
// -----------------------------------------------------------------------------
module rr_prio_pick #(
    parameter int N_REQ = 4,
    parameter int SEL_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_vld,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] winner,
    output logic             any
);

    int               idx;
    logic [SEL_W-1:0] idx_s;

    // Scan from the lowest priority to the highest so the last hit wins.
    always_comb begin
        winner = '0;
        idx    = 0;
        idx_s  = '0;
        any    = |req_vld;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            idx_s = SEL_W'(idx);
            if (req_vld[idx_s]) begin
                winner = idx_s;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter
// Round-robin arbiter driving a shared N-way mux between N_REQ valid/ready
// producers and one consumer. Holds the select stable across a stalled
// transfer and rotates priority after every completed handshake.
// Build option: MUX_RR_ARB_OUT_REG_EN adds a one-entry output register
// (1-cycle latency, FSM stays in ARB); undefined gives a zero-latency path.
// Ports:
//   clk, rst              clock, async active-high reset
//   req_vld  [N_REQ]      per-requester valid
//   req_data [N_REQ][W]   per-requester data
//   req_rdy  [N_REQ]      per-requester ready (one-hot or zero)
//   out_vld, out_data[W]  consumer side valid/data
//   out_src  [SEL_W]      index of the requester on out_data
//   out_rdy               consumer ready
// -----------------------------------------------------------------------------
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int W     = W_DEF,
    parameter int SEL_W = $clog2(N_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_vld,
    input  logic [N_REQ-1:0][W-1:0]  req_data,
    output logic [N_REQ-1:0]         req_rdy,
    output logic                     out_vld,
    output logic [W-1:0]             out_data,
    output logic [SEL_W-1:0]         out_src,
    input  logic                     out_rdy
);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] winner;
    logic [SEL_W-1:0] grant;
    logic             any;
    logic             hs;

    rr_prio_pick #(
        .N_REQ (N_REQ),
        .SEL_W (SEL_W)
    ) u_pick (
        .req_vld (req_vld),
        .ptr     (ptr),
        .winner  (winner),
        .any     (any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (hs) begin
            ptr <= SEL_W'(wrap_inc(int'(grant), N_REQ));
        end
    end

`ifdef MUX_RR_ARB_OUT_REG_EN

    logic             full;
    logic             take;
    logic [W-1:0]     data_q;
    logic [SEL_W-1:0] src_q;

    // The register absorbs consumer stalls, so the requester side never
    // needs the select frozen; LOCK is never entered.
    always_comb begin
        state_nxt = ARB;
    end

    assign take  = !rst && any && (state == ARB) && (!full || out_rdy);
    assign grant = winner;
    assign hs    = take;

    always_comb begin
        req_rdy = '0;
        if (take) begin
            req_rdy[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full   <= 1'b0;
            data_q <= '0;
            src_q  <= '0;
        end else if (take) begin
            full   <= 1'b1;
            data_q <= req_data[winner];
            src_q  <= winner;
        end else if (out_rdy) begin
            full   <= 1'b0;
        end
    end

    assign out_vld  = full;
    assign out_data = data_q;
    assign out_src  = src_q;

`else

    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] sel;

    // Outputs are forced to zero while rst is high so no handshake can be
    // seen during reset even though the path is combinational.
    always_comb begin
        sel      = (state == LOCK) ? sel_q : winner;
        out_vld  = !rst && req_vld[sel];
        out_data = rst ? '0 : req_data[sel];
        out_src  = rst ? '0 : sel;
        req_rdy  = '0;
        if (out_vld) begin
            req_rdy[sel] = out_rdy;
        end
    end

    assign grant = sel;
    assign hs    = out_vld && out_rdy;

    // A dropped valid in LOCK returns to ARB without a transfer.
    always_comb begin
        state_nxt = state;
        case (state)
            ARB:     if (out_vld && !out_rdy)         state_nxt = LOCK;
            LOCK:    if (out_rdy || !req_vld[sel_q])  state_nxt = ARB;
            default:                                  state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q <= '0;
        end else if (state == ARB && state_nxt == LOCK) begin
            sel_q <= winner;
        end
    end

`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;

    typedef struct {
        logic [1:0] src;
        logic [7:0] data;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [3:0]       req_vld;
    logic [3:0][7:0]  req_data;
    logic [3:0]       req_rdy;
    logic             out_vld;
    logic [7:0]       out_data;
    logic [1:0]       out_src;
    logic             out_rdy;

    logic [2:0]       req_vld3;
    logic [2:0][7:0]  req_data3;
    logic [2:0]       req_rdy3;
    logic             out_vld3;
    logic [7:0]       out_data3;
    logic [1:0]       out_src3;
    logic             out_rdy3;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    int         quota [4];
    int         sent  [4];
    logic [7:0] base  [4];
    logic [3:0] hs_cap;

    bit t3_on = 0;
    int k3    = 0;
    int exp3 [6];
    int cyc;

    mux_rr_arbiter #(.N_REQ(4), .W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_vld  (req_vld),
        .req_data (req_data),
        .req_rdy  (req_rdy),
        .out_vld  (out_vld),
        .out_data (out_data),
        .out_src  (out_src),
        .out_rdy  (out_rdy)
    );

    mux_rr_arbiter #(.N_REQ(3), .W(8)) dut3 (
        .clk      (clk),
        .rst      (rst),
        .req_vld  (req_vld3),
        .req_data (req_data3),
        .req_rdy  (req_rdy3),
        .out_vld  (out_vld3),
        .out_data (out_data3),
        .out_src  (out_src3),
        .out_rdy  (out_rdy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] src, input logic [7:0] data);
        exp_t e;
        e.src  = src;
        e.data = data;
        exp_q.push_back(e);
    endtask

    function automatic void drive();
        for (int i = 0; i < 4; i++) begin
            req_vld[i]  = (sent[i] < quota[i]);
            req_data[i] = 8'(base[i] + 8'(sent[i]));
        end
    endfunction

    function automatic void clear_src();
        for (int i = 0; i < 4; i++) begin
            quota[i] = 0;
            sent[i]  = 0;
            base[i]  = 8'h00;
        end
    endfunction

    task automatic wait_drain(input int max, input bit toggle, output int cycles);
        cycles = 0;
        while (exp_q.size() != 0 && cycles < max) begin
            @(posedge clk);
            #2;
            if (toggle) out_rdy = ~out_rdy;
            cycles++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d outputs still pending after %0d cycles", exp_q.size(), cycles);
            exp_q.delete();
        end
    endtask

    // Scoreboard monitor: one comparison per completed output transfer.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_vld && out_rdy) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_out: got src=%0d data=%h expected no transfer", out_src, out_data);
            end else begin
                e = exp_q.pop_front();
                n_vec++;
                if (out_src !== e.src || out_data !== e.data) begin
                    n_err++;
                    $display("FAIL out_xfer: got src=%0d data=%h expected src=%0d data=%h",
                             out_src, out_data, e.src, e.data);
                end
            end
        end
        hs_cap = rst ? 4'b0000 : (req_vld & req_rdy);
    end

    // Three-requester instance: grant order must wrap 2 -> 0.
    always @(negedge clk) begin
        if (!rst && t3_on && out_vld3 && k3 < 6) begin
            chk("n3_src", 32'(out_src3), 32'(exp3[k3]));
            chk("n3_data", 32'(out_data3), 32'(8'hC0 + 8'(exp3[k3])));
            chk("n3_ptr_lt3", 32'(dut3.ptr < 2'd3), 32'd1);
            k3++;
        end
    end

    // Requester model: advance a source only after its handshake.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 4; i++) begin
            if (hs_cap[i]) sent[i]++;
        end
        hs_cap = 4'b0000;
        drive();
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got %0d vectors expected completion", n_vec);
        $fatal(1, "watchdog timeout");
    end

    initial begin
        exp3[0] = 0; exp3[1] = 1; exp3[2] = 2;
        exp3[3] = 0; exp3[4] = 1; exp3[5] = 2;
        hs_cap    = 4'b0000;
        rst       = 1'b1;
        out_rdy   = 1'b0;
        out_rdy3  = 1'b1;
        req_vld3  = 3'b111;
        req_data3 = {8'hC2, 8'hC1, 8'hC0};

        // T1: reset held with everything valid, then free-running rotation.
        clear_src();
        for (int i = 0; i < 4; i++) begin
            quota[i] = 2;
            base[i]  = 8'(i * 16);
        end
        drive();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_vld", 32'(out_vld), 32'd0);
        chk("rst_req_rdy", 32'(req_rdy), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_src", 32'(out_src), 32'd0);
        chk("rst_ptr", 32'(dut.ptr), 32'd0);
        push(2'd0, 8'h00); push(2'd1, 8'h10); push(2'd2, 8'h20); push(2'd3, 8'h30);
        push(2'd0, 8'h01); push(2'd1, 8'h11); push(2'd2, 8'h21); push(2'd3, 8'h31);
        @(posedge clk);
        #2;
        rst     = 1'b0;
        out_rdy = 1'b1;
        t3_on   = 1'b1;
        wait_drain(20, 1'b0, cyc);
        chk("t1_back_to_back", 32'(cyc <= 9), 32'd1);
        chk("n3_samples", 32'(k3), 32'd6);
        req_vld3 = 3'b000;
        t3_on    = 1'b0;

        // T2: stall on requester 1 with 3 pending; 0 arrives mid-stall.
        clear_src();
        quota[1] = 1; base[1] = 8'h11;
        quota[3] = 1; base[3] = 8'h33;
        out_rdy  = 1'b0;
        drive();
        push(2'd1, 8'h11); push(2'd3, 8'h33); push(2'd0, 8'h0A);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                chk("stall_out_vld", 32'(out_vld), 32'd1);
                chk("stall_out_src", 32'(out_src), 32'd1);
                chk("stall_req_rdy", 32'(req_rdy), 32'd0);
            end
            @(posedge clk);
            #2;
            if (c == 2) begin
                quota[0] = 1;
                base[0]  = 8'h0A;
                drive();
            end
        end
        out_rdy = 1'b1;
        wait_drain(20, 1'b0, cyc);
        chk("t2_ptr", 32'(dut.ptr), 32'd1);

        // T3: single requester 2.
        clear_src();
        quota[2] = 1; base[2] = 8'hA5;
        drive();
        push(2'd2, 8'hA5);
        @(negedge clk);
        chk("t3_req_rdy", 32'(req_rdy), 32'b0100);
        wait_drain(20, 1'b0, cyc);
        chk("t3_ptr", 32'(dut.ptr), 32'd3);

        // T4: reset pulsed while stalled on requester 3 (ptr = 3).
        clear_src();
        quota[0] = 1; base[0] = 8'h50;
        quota[3] = 1; base[3] = 8'h53;
        out_rdy  = 1'b0;
        drive();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t4_stall_vld", 32'(out_vld), 32'd1);
        chk("t4_stall_src", 32'(out_src), 32'd3);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        chk("t4_rst_out_vld", 32'(out_vld), 32'd0);
        chk("t4_rst_out_data", 32'(out_data), 32'd0);
        chk("t4_rst_out_src", 32'(out_src), 32'd0);
        chk("t4_rst_req_rdy", 32'(req_rdy), 32'd0);
        chk("t4_rst_ptr", 32'(dut.ptr), 32'd0);
        push(2'd0, 8'h50);
`ifndef MUX_RR_ARB_OUT_REG_EN
        // Zero-latency path: requester 3 never completed its handshake.
        push(2'd3, 8'h53);
`endif
        @(posedge clk);
        #2;
        rst     = 1'b0;
        out_rdy = 1'b1;
        wait_drain(20, 1'b0, cyc);

        // T5: all valid, out_rdy toggling, from a fresh pointer.
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        clear_src();
        for (int i = 0; i < 4; i++) begin
            quota[i] = 2;
            base[i]  = 8'(8'h80 + i * 16);
        end
        out_rdy = 1'b1;
        drive();
        push(2'd0, 8'h80); push(2'd1, 8'h90); push(2'd2, 8'hA0); push(2'd3, 8'hB0);
        push(2'd0, 8'h81); push(2'd1, 8'h91); push(2'd2, 8'hA1); push(2'd3, 8'hB1);
        wait_drain(40, 1'b1, cyc);
        out_rdy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t5_idle_out_vld", 32'(out_vld), 32'd0);
        chk("t5_ptr", 32'(dut.ptr), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that shares one N-way multiplexer datapath among `N_REQ` requesters, each presenting data under a valid/ready handshake. It owns the mux select, sequences grants fairly, and holds the select stable for the whole of a stalled transfer. It sits between several producers and a single consumer port.

## Interface

- `N_REQ`, default 4: number of requesters, from 2 to 16.
- `W`, default 8: data width in bits.
- `SEL_W`, default `$clog2(N_REQ)`: select/source index width. This is a derived parameter and must not be overridden.

- `clk`  in  1  Single clock; all logic is rising-edge.
- `rst`  in  1  Asynchronous, active-high reset.
- `req_vld`  in  `N_REQ`  Per-requester valid.
- `req_data`  in  `[N_REQ-1:0][W-1:0]`  Per-requester data.
- `req_rdy`  out  `N_REQ`  Per-requester ready. The bits are one-hot or all zero.
- `out_vld`  out  1  Output valid.
- `out_data`  out  `W`  Output data.
- `out_src`  out  `SEL_W`  Index of the requester whose data is on `out_data`.
- `out_rdy`  in  1  Consumer ready.

## Operation

- A transfer completes on a requester when `req_vld[i] && req_rdy[i]`. It completes on the output when `out_vld && out_rdy`.
- Requester rule: once `req_vld[i]` is raised, it and `req_data[i]` hold until the handshake completes.
- Rotating pointer `ptr` (`SEL_W` bits) has reset value 0.
  - The winner is the first `i` with `req_vld[i]` set, scanning `ptr, ptr+1, … N_REQ-1, 0, … ptr-1`.
- FSM, states `ARB` and `LOCK`:
  - `ARB`: the select is the combinational winner. If `out_vld && !out_rdy`, latch the select into `sel_q` and go to `LOCK`.
  - `LOCK`: the select is `sel_q`, with no re-arbitration. On `out_rdy`, complete the transfer and return to `ARB`.
  - If `req_vld[sel_q]` drops while in `LOCK` (a protocol violation), return to `ARB` next cycle with no transfer.
- On every completed requester handshake, `ptr <= (granted index + 1)` modulo `N_REQ`. The step from `N_REQ-1` wraps to 0, including when `N_REQ` is not a power of 2.
- When no requester is valid: `out_vld=0`, `req_rdy=0`, `ptr` unchanged.
- Starvation bound: a continuously valid requester is granted within `N_REQ` completed transfers.

## Timing

- Reset values: `req_rdy=0`, `out_vld=0`, `out_data=0`, `out_src=0`, `ptr=0`, state `ARB`, output register empty.
- Reset asserted mid-transfer aborts it. No handshake is reported in the cycle `rst` is high.
- Without `MUX_RR_ARB_OUT_REG_EN`:
  - Zero latency: `out_vld = req_vld[sel]`, `out_data = req_data[sel]`, `out_src = sel`.
  - `req_rdy[sel] = out_rdy`.
  - Throughput is one transfer per cycle.
- With `MUX_RR_ARB_OUT_REG_EN`: see Configuration.
- Arbitration decision and `ptr` update take 1 cycle. A new winner is visible the cycle after the previous handshake.

## Configuration

- `MUX_RR_ARB_OUT_REG_EN` defined: adds a one-entry output register.
  - `out_vld`, `out_data` and `out_src` are flops. Latency is 1 cycle.
  - `req_rdy[winner] = !full || out_rdy`, giving one transfer per cycle under continuous `out_rdy`.
  - Register contents hold while `out_vld && !out_rdy`.
  - `LOCK` is unused, because the register breaks the stall path. The FSM stays in `ARB`.
- Undefined: purely combinational output path, as described in Timing.

## Structure

- Package `mux_arb_pkg` holds:
  - `typedef enum logic [0:0] {ARB, LOCK} arb_state_t`.
  - Default `N_REQ`/`W` localparams.
  - A `function` computing the wrap-around increment modulo `N_REQ`.
- One sub-module, `rr_prio_pick`: combinational rotating-priority picker. Inputs are `req_vld` and `ptr`; outputs are winner index and `any`.
- Top level: FSM, pointer, mux, and optional output register.

## Test plan

- Reset held with all `req_vld=1`, then released with `out_rdy=1`: `out_src` sequence is 0,1,2,3,0,1 on consecutive cycles (register build: starts one cycle later).
- Only requester 2 valid, `req_data[2]=8'hA5`, `out_rdy=1`: `out_data=8'hA5`, `out_src=2`, `req_rdy=4'b0100`. Next grant scan starts at 3.
- Requesters 1 and 3 valid, `out_rdy=0` for 5 cycles, then 1: `out_src` stays 1 throughout the stall. Requester 1 transfers first, then 3.
- `N_REQ=3`, all valid, `out_rdy=1`: `out_src` is 0,1,2,0; `ptr` never reaches 3.
- `rst` pulsed while `out_vld=1` and stalled: next cycle all outputs are 0 and `ptr=0`. Arbitration restarts at requester 0.
- `out_rdy` toggling 1,0,1,0 with all valid: each requester is granted exactly once per 4 completed transfers and no data is duplicated or dropped.
